piso_stream_scheduler: RTL and testbench
========================================

Name: piso_stream_scheduler

Overview:
- Round-robin scheduler that shares one PISO feature serializer among NREQ requesters in the aggregation engine.
- Accepts one whole feature vector (WIDTH*DEPTH bits) per grant and drives the PISO parallel-load port.
- Then paces PISO reads against a valid/ready downstream, tagging each beat with its source id and a last flag.
- Sits between the per-node feature fetch units and the serial aggregation datapath.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, feature element width in bits.
- DEPTH, FEATURES (my_pkg), elements per vector. Must equal FEATURES, because the PISO read pointer wraps modulo FEATURES.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester vector valid.
- req_data  in  NREQ*WIDTH*DEPTH  packed vectors; requester i occupies slice i.
- req_ready  out  NREQ  one-hot grant/accept pulse.
- piso_din  out  WIDTH*DEPTH  vector to the PISO.
- piso_we  out  1  PISO load strobe.
- piso_re  out  1  PISO read enable.
- piso_qout  in  WIDTH  PISO serial output.
- piso_empty  in  1  PISO empty.
- piso_full  in  1  PISO full.
- out_valid  out  1  serial beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  WIDTH  serial beat; equals piso_qout.
- out_src  out  $clog2(NREQ)  owner id of the current vector.
- out_last  out  1  final beat of the vector.
- busy  out  1  scheduler not in IDLE.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, arst_n=0): state IDLE; rr_ptr=0, so requester 0 has highest priority; beat_cnt=0; owner=0; err=0. All outputs 0.
- States: IDLE, LOAD, STREAM.
- IDLE:
  - if any req_valid and piso_empty: pick winner w = first valid index at or after rr_ptr, wrapping.
  - Same cycle: req_ready[w]=1, piso_we=1, piso_din=req_data slice w.
  - Register owner=w and rr_ptr=(w+1) mod NREQ; go to LOAD.
  - if piso_empty=0: grant nothing.
- LOAD: one-cycle settle while the PISO updates empty/full. Expect piso_full=1; if not, set err. Go to STREAM with beat_cnt=0.
- STREAM:
  - out_valid = !piso_empty.
  - piso_re = out_valid & out_ready.
  - out_data = piso_qout, meaningful only when the beat is accepted (PISO outputs 0 when not read).
  - out_src = owner.
  - out_last = (beat_cnt==DEPTH-1) & out_valid.
  - Each accepted beat increments beat_cnt.
  - Accepted last beat -> IDLE, beat_cnt=0.
- Latency: grant to first out_valid is 2 cycles. Minimum vector period is DEPTH+2 cycles.
- Never assert piso_we and piso_re in the same cycle: the PISO load-and-last-read collision corrupts empty. IDLE is therefore mandatory between vectors (1-cycle bubble).
- piso_din holds 0 when piso_we=0.
- Stall: out_ready=0 holds beat_cnt, state and owner; no read is issued.
- Error conditions (err is sticky until reset; scheduling continues):
  - piso_empty=1 in STREAM before beat DEPTH.
  - piso_full=0 in LOAD.
- req_valid dropping before grant is legal (no request is latched). The payload is only sampled on the grant cycle.
- Single requester repeatedly valid: granted every DEPTH+2 cycles.
- Reset mid-STREAM: returns to IDLE immediately. The PISO resets on the same arst_n.
- busy = (state != IDLE).

Decomposition:
- my_pkg additions:
  - typedef enum sched_state_t {IDLE, LOAD, STREAM}.
  - constant SRC_W = $clog2(NREQ_DEFAULT).
  - FEATURES is reused as DEPTH.
- Registers use the team REG macro.
- One sub-module: rr_arbiter (NREQ; req, ptr in; one-hot grant and index out; purely combinational).
- The PISO is instantiated by the parent, not inside this block.

Test Plan:
- Single vector: NREQ=4, DEPTH=16, WIDTH=8; req_valid=4'b0010 with bytes 0x00..0x0F; out_ready=1.
  -> req_ready=4'b0010 for 1 cycle.
  -> 16 beats 0x00..0x0F on consecutive cycles starting 2 cycles after grant, out_src=1.
  -> out_last on beat 16 only; back to IDLE.
- Round-robin fairness: req_valid=4'b1111 held for 4 vectors.
  -> grant order 0,1,2,3; each vector 18 cycles apart.
  -> then req_valid=4'b1001 gives order 0,3,0,3.
- Backpressure: out_ready toggles 1,0,1,0 during STREAM.
  -> 16 beats still delivered in order, with no duplicates or drops.
  -> piso_re never asserted while out_ready=0.
- No load/read overlap: back-to-back requests.
  -> piso_we and piso_re never high in the same cycle (assertion).
  -> one IDLE cycle separates the last beat and the next grant.
- Error: force piso_empty=1 at beat 5 in STREAM.
  -> err=1 and remains 1.
  -> the next request is still served.
- Reset mid-stream: arst_n low at beat 7.
  -> all outputs 0 asynchronously.
  -> after release, req_valid=4'b0100 is granted with rr_ptr reset (requester 2 granted), and a fresh 16-beat stream follows.

Source files
------------

// File: rtl/piso_stream_scheduler_pkg.sv
// Shared types and sizing for the PISO stream scheduler.
package piso_stream_scheduler_pkg;
    localparam int FEATURES     = 16;
    localparam int NREQ_DEFAULT = 4;
    localparam int SRC_W        = $clog2(NREQ_DEFAULT);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} sched_state_t;
endpackage

// File: rtl/piso_stream_scheduler_if.sv
// Requester, PISO and downstream signals of the scheduler; master is the scheduler side.
interface piso_stream_scheduler_if
    import piso_stream_scheduler_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int WIDTH = 8,
    parameter int DEPTH = FEATURES
) ();
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0]                        req_valid;
    logic [NREQ-1:0][DEPTH-1:0][WIDTH-1:0]  req_data;
    logic [NREQ-1:0]                        req_ready;
    logic [DEPTH-1:0][WIDTH-1:0]            piso_din;
    logic                                   piso_we;
    logic                                   piso_re;
    logic [WIDTH-1:0]                       piso_qout;
    logic                                   piso_empty;
    logic                                   piso_full;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [WIDTH-1:0]                       out_data;
    logic [SW-1:0]                          out_src;
    logic                                   out_last;

    modport master (
        input  req_valid, req_data, piso_qout, piso_empty, piso_full, out_ready,
        output req_ready, piso_din, piso_we, piso_re, out_valid, out_data, out_src, out_last
    );

    modport slave (
        output req_valid, req_data, piso_qout, piso_empty, piso_full, out_ready,
        input  req_ready, piso_din, piso_we, piso_re, out_valid, out_data, out_src, out_last
    );
endinterface

// File: rtl/piso_stream_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rr_arbiter
    import piso_stream_scheduler_pkg::*;
#(
    parameter  int NREQ = NREQ_DEFAULT,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        any   = |req;
        // Scan from the farthest offset down so the nearest one to ptr wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end
endmodule

// File: rtl/piso_stream_scheduler.sv
// Round-robin scheduler feeding one shared PISO: load a whole vector per grant,
// then drain it beat by beat toward a valid/ready consumer.
module piso_stream_scheduler
    import piso_stream_scheduler_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int WIDTH = 8,
    parameter int DEPTH = FEATURES
) (
    input  logic                    clk,
    input  logic                    arst_n,
    piso_stream_scheduler_if.master bus,
    output logic                    busy,
    output logic                    err
);
    localparam int SW = $clog2(NREQ);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sched_state_t    state, state_nxt;
    logic [SW-1:0]   rr_ptr, ptr_nxt, owner, owner_nxt, win;
    logic [CW-1:0]   beat_cnt, cnt_nxt;
    logic            err_nxt, any, beat_ok, at_last;
    logic [NREQ-1:0] gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (win),
        .any   (any)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= cnt_nxt;
            err      <= err_nxt;
        end
    end

    assign at_last = (beat_cnt == CW'(DEPTH - 1));

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = rr_ptr;
        owner_nxt     = owner;
        cnt_nxt       = beat_cnt;
        err_nxt       = err;
        beat_ok       = 1'b0;
        bus.req_ready = '0;
        bus.piso_we   = 1'b0;
        bus.piso_din  = '0;
        bus.piso_re   = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        unique case (state)
            IDLE: begin
                // A load only lands on a drained PISO, so we and re never coincide.
                if (any && bus.piso_empty) begin
                    bus.req_ready = gnt;
                    bus.piso_we   = 1'b1;
                    bus.piso_din  = bus.req_data[win];
                    owner_nxt     = win;
                    ptr_nxt       = (win == SW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_nxt     = LOAD;
                end
            end
            LOAD: begin
                if (!bus.piso_full) err_nxt = 1'b1;
                cnt_nxt   = '0;
                state_nxt = STREAM;
            end
            STREAM: begin
                beat_ok       = !bus.piso_empty && bus.out_ready;
                bus.out_valid = !bus.piso_empty;
                bus.piso_re   = beat_ok;
                bus.out_data  = bus.piso_qout;
                bus.out_last  = at_last && !bus.piso_empty;
                if (bus.piso_empty) err_nxt = 1'b1;
                if (beat_ok) begin
                    if (at_last) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_src = owner;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_piso_stream_scheduler.sv
// Bench for piso_stream_scheduler: behavioural PISO, queue scoreboard, vector table, random traffic.
module tb_piso_stream_scheduler;
    import piso_stream_scheduler_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = FEATURES;
    localparam int PW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic busy, err;
    logic force_empty = 1'b0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    piso_stream_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    piso_stream_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural PISO: parallel load fills it, each read shifts out the next element.
    logic [DEPTH-1:0][WIDTH-1:0] pmem;
    int                          pcnt;
    logic [PW-1:0]               prd;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pmem <= '0;
            pcnt <= 0;
            prd  <= '0;
        end else if (bus.piso_we) begin
            pmem <= bus.piso_din;
            pcnt <= DEPTH;
            prd  <= '0;
        end else if (bus.piso_re && pcnt > 0) begin
            pcnt <= pcnt - 1;
            prd  <= prd + 1'b1;
        end
    end

    assign bus.piso_empty = (pcnt == 0) || force_empty;
    assign bus.piso_full  = (pcnt == DEPTH);
    assign bus.piso_qout  = bus.piso_re ? pmem[prd] : '0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no response within cycle budget at t=%0t", name, $time);
    endtask

    // Scoreboard: each grant queues the DEPTH beats the owner's vector must produce.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               src;
        logic             last;
    } beat_t;

    beat_t q[$];
    int    m_ptr = 0;
    bit    m_load = 0;
    bit    m_err = 0;

    always @(negedge clk) begin
        if (!arst_n) begin
            q.delete();
            m_ptr  = 0;
            m_load = 0;
            m_err  = 0;
        end else begin
            bit              idle, streaming, exp_v, exp_g;
            int              w;
            logic [NREQ-1:0] exp_rdy;
            beat_t           b;
            idle      = (q.size() == 0);
            streaming = !idle && !m_load;
            exp_v     = streaming && !bus.piso_empty;
            chk("busy", busy, !idle);
            chk("out_valid", bus.out_valid, exp_v);
            chk("piso_re", bus.piso_re, exp_v && bus.out_ready);
            chk("we_re_overlap", bus.piso_we && bus.piso_re, 1'b0);
            chk("out_last", bus.out_last, exp_v && q.size() == 1);
            if (exp_v) chk("out_src", bus.out_src, q[0].src);
            if (exp_v && bus.out_ready) begin
                chk("out_data", bus.out_data, q[0].data);
                void'(q.pop_front());
            end
            exp_g   = idle && (|bus.req_valid) && bus.piso_empty;
            exp_rdy = '0;
            w       = 0;
            if (exp_g) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (bus.req_valid[(m_ptr + k) % NREQ]) begin
                        w = (m_ptr + k) % NREQ;
                        break;
                    end
                end
                exp_rdy[w] = 1'b1;
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("piso_we", bus.piso_we, exp_g);
            chk("piso_din", bus.piso_din, exp_g ? bus.req_data[w] : '0);
            chk("err", err, m_err);
            if (m_load && !bus.piso_full) m_err = 1;
            if (streaming && bus.piso_empty) m_err = 1;
            m_load = exp_g;
            if (exp_g) begin
                for (int k = 0; k < DEPTH; k++) begin
                    b.data = bus.req_data[w][k];
                    b.src  = w;
                    b.last = (k == DEPTH - 1);
                    q.push_back(b);
                end
                m_ptr = (w + 1) % NREQ;
            end
        end
    end

    task automatic set_req(input logic [NREQ-1:0] v, input bit ramp);
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < DEPTH; k++)
                bus.req_data[i][k] = ramp ? WIDTH'(k) : WIDTH'($urandom_range(0, 255));
        bus.req_valid = v;
    endtask

    task automatic wait_grant(output int g, output logic [NREQ-1:0] r);
        int t = 0;
        g = -1;
        r = '0;
        while (t < 200) begin
            @(negedge clk);
            t++;
            if (|bus.req_ready) begin
                g = cyc;
                r = bus.req_ready;
                break;
            end
        end
        if (g < 0) timeout("grant_wait");
    endtask

    task automatic wait_beats(input int n, output int first_c, output int last_c, output int last_idx);
        int got = 0;
        int t = 0;
        first_c = -1;
        last_c = -1;
        last_idx = -1;
        while (got < n && t < 400) begin
            @(negedge clk);
            t++;
            if (bus.out_valid && bus.out_ready) begin
                got++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                if (bus.out_last) last_idx = got;
            end
        end
        chk("beat_count", got, n);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 400);
        if (busy) timeout("idle_wait");
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 arst_n = 1'b0;
        @(posedge clk);
        #2 arst_n = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
        int              toggle;
        int              gap;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int              g, prev_g, f, l, li;
        logic [NREQ-1:0] r;

        tbl[0]  = '{4'b1111, 4'b0001, 0, 0};
        tbl[1]  = '{4'b1111, 4'b0010, 0, 18};
        tbl[2]  = '{4'b1111, 4'b0100, 0, 18};
        tbl[3]  = '{4'b1111, 4'b1000, 0, 18};
        tbl[4]  = '{4'b1001, 4'b0001, 0, 18};
        tbl[5]  = '{4'b1001, 4'b1000, 0, 18};
        tbl[6]  = '{4'b1001, 4'b0001, 0, 18};
        tbl[7]  = '{4'b1001, 4'b1000, 0, 18};
        tbl[8]  = '{4'b0100, 4'b0100, 1, 18};
        tbl[9]  = '{4'b0011, 4'b0001, 0, 0};
        tbl[10] = '{4'b0110, 4'b0010, 0, 18};

        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req_ready", bus.req_ready, '0);
        chk("rst_piso_we", bus.piso_we, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_src", bus.out_src, '0);
        @(posedge clk);
        #2 arst_n = 1'b1;

        // Single vector from requester 1, ramp payload.
        @(posedge clk);
        #1 set_req(4'b0010, 1'b1);
        wait_grant(g, r);
        chk("single_grant", r, 4'b0010);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_beats(DEPTH, f, l, li);
        chk("single_first_latency", f - g, 2);
        chk("single_last_cycle", l - g, DEPTH + 1);
        chk("single_last_index", li, DEPTH);
        wait_idle();

        // Round-robin table, rr pointer restarted from 0.
        pulse_reset();
        prev_g = 0;
        #1 set_req(tbl[0].valid, 1'b0);
        for (int i = 0; i < 11; i++) begin
            wait_grant(g, r);
            chk($sformatf("tbl%0d_grant", i), r, tbl[i].exp_ready);
            if (tbl[i].gap != 0) chk($sformatf("tbl%0d_gap", i), g - prev_g, tbl[i].gap);
            prev_g = g;
            @(posedge clk);
            #1;
            rdy_mode = tbl[i].toggle;
            if (i < 10) set_req(tbl[i + 1].valid, 1'b0);
            else bus.req_valid = '0;
        end
        wait_idle();
        rdy_mode = 0;

        // Random requesters, payloads and backpressure against the scoreboard.
        rdy_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) bus.req_valid = '0;
            else if ($urandom_range(0, 1) == 0) set_req(NREQ'($urandom), 1'b0);
            else bus.req_valid = NREQ'($urandom);
        end
        bus.req_valid = '0;
        rdy_mode = 0;
        wait_idle();
        chk("pre_err_clear", err, 1'b0);

        // Premature empty during streaming: err sticks, scheduling carries on.
        pulse_reset();
        #1 set_req(4'b0001, 1'b0);
        wait_grant(g, r);
        chk("errtest_grant", r, 4'b0001);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_beats(5, f, l, li);
        @(posedge clk);
        #1 force_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_empty = 1'b0;
        chk("err_set", err, 1'b1);
        wait_beats(DEPTH - 5, f, l, li);
        chk("err_stream_last", li, DEPTH - 5);
        wait_idle();
        set_req(4'b0100, 1'b0);
        wait_grant(g, r);
        chk("err_next_grant", r, 4'b0100);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_beats(DEPTH, f, l, li);
        wait_idle();
        chk("err_sticky", err, 1'b1);

        // Reset in the middle of a stream.
        set_req(4'b1000, 1'b0);
        wait_grant(g, r);
        chk("midrst_grant", r, 4'b1000);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_beats(7, f, l, li);
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_out_last", bus.out_last, 1'b0);
        chk("midrst_out_src", bus.out_src, '0);
        chk("midrst_out_data", bus.out_data, '0);
        chk("midrst_piso_re", bus.piso_re, 1'b0);
        chk("midrst_piso_we", bus.piso_we, 1'b0);
        chk("midrst_piso_din", bus.piso_din, '0);
        chk("midrst_req_ready", bus.req_ready, '0);
        @(posedge clk);
        #2 arst_n = 1'b1;
        set_req(4'b0100, 1'b0);
        wait_grant(g, r);
        chk("postrst_grant", r, 4'b0100);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_beats(DEPTH, f, l, li);
        chk("postrst_first_latency", f - g, 2);
        chk("postrst_last_index", li, DEPTH);
        wait_idle();
        chk("postrst_err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
